// File: rtl/sib_scan_sequencer.sv
// sib_scan_sequencer: runs one capture-shift-update access on an IJTAG SIB
// chain per host request and returns the bits shifted out of the chain root.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; nothing driven on the chain
// CAPTURE | one cycle of Select+CaptureEN
// SHIFT   | Select+ShiftEN, one bit in/out per cycle until cnt hits 1
// UPDATE  | one cycle of Select+UpdateEn, result latched into rdata
// DONE    | one-cycle done pulse
// ERR     | one-cycle err pulse (bad length or abort)
module sib_scan_sequencer #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              ScanSI,
  input  logic              ScanSO,
  output logic              Select,
  output logic              CaptureEN,
  output logic              ShiftEN,
  output logic              UpdateEn
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(DATA_W);
  localparam logic [LEN_W:0]   DATA_W_X = (LEN_W+1)'(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic              len_ok;
  logic [LEN_W:0]    align_sh;

  // Zero length would make cnt wrap, so it is rejected alongside over-length.
  assign len_ok   = (len != '0) && (len <= MAX_LEN);
  // Received bits enter at the MSB; this shift right-aligns the last len bits.
  assign align_sh = DATA_W_X - {1'b0, len_q};

  // Serial out is only meaningful while shifting; held low otherwise.
  assign ScanSI = ShiftEN & sreg[0];

  // Sequencer FSM with all status and chain-control outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      len_q     <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      Select    <= 1'b0;
      CaptureEN <= 1'b0;
      ShiftEN   <= 1'b0;
      UpdateEn  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len_ok) begin
              sreg      <= wdata;
              cnt       <= len;
              len_q     <= len;
              Select    <= 1'b1;
              CaptureEN <= 1'b1;
              state     <= CAPTURE;
            end else begin
              err   <= 1'b1;
              state <= ERR;
            end
          end
        end
        CAPTURE: begin
          CaptureEN <= 1'b0;
          if (abort) begin
            Select <= 1'b0;
            err    <= 1'b1;
            state  <= ERR;
          end else begin
            ShiftEN <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            // Abort wins over the final shift: sreg is left untouched.
            ShiftEN <= 1'b0;
            Select  <= 1'b0;
            err     <= 1'b1;
            state   <= ERR;
          end else begin
            sreg <= {ScanSO, sreg[DATA_W-1:1]};
            cnt  <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
              ShiftEN  <= 1'b0;
              UpdateEn <= 1'b1;
              state    <= UPDATE;
            end
          end
        end
        UPDATE: begin
          rdata    <= sreg >> align_sh;
          UpdateEn <= 1'b0;
          Select   <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
          Select    <= 1'b0;
          CaptureEN <= 1'b0;
          ShiftEN   <= 1'b0;
          UpdateEn  <= 1'b0;
        end
      endcase
    end
  end

  // At most one SIB enable at a time, and Select tracks exactly their union.
  a_ctl_onehot: assert property (@(posedge clk)
    $onehot0({CaptureEN, ShiftEN, UpdateEn}) &&
    (Select == (CaptureEN | ShiftEN | UpdateEn)));

endmodule

// File: tb/tb_sib_scan_sequencer.sv
// Bench for sib_scan_sequencer: directed scenarios plus random accesses,
// all checked against a cycle timeline and a bit-level chain model.
module tb_sib_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  len = '0;
  logic [31:0] wdata = '0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        ScanSI, ScanSO;
  logic        Select, CaptureEN, ShiftEN, UpdateEn;

  int          n_cmp = 0;
  int          n_bad = 0;

  // Behavioural SIB chain: ch_len bits, SO is bit 0, SI enters at the top.
  logic [63:0] chain = '0;
  int          ch_len = 8;
  logic        ld = 1'b0;
  logic [63:0] ld_val = '0;
  logic [31:0] rd_model = '0;

  sib_scan_sequencer #(.DATA_W(32), .LEN_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .wdata(wdata),
    .abort(abort), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .ScanSI(ScanSI), .ScanSO(ScanSO), .Select(Select),
    .CaptureEN(CaptureEN), .ShiftEN(ShiftEN), .UpdateEn(UpdateEn)
  );

  always #5 clk = ~clk;

  assign ScanSO = chain[0];

  always @(posedge clk) begin
    if (ld) chain <= ld_val;
    else if (ShiftEN) chain <= (chain >> 1) | (64'(ScanSI) << (ch_len - 1));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_chain(input int l, input logic [63:0] v);
    ch_len = l;
    ld_val = v & ((64'd1 << l) - 64'd1);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // One request. abort_k / restart_k / rst_k give the cycle (1 = first cycle
  // after start is sampled) in which that input is raised; 0 means never.
  task automatic do_access(input int n, input logic [31:0] w,
                           input int abort_k, input int restart_k, input int rst_k);
    logic [63:0] snap, exp_chain, m;
    logic [31:0] exp_rd;
    logic [6:0]  exp_v, obs_v;
    logic        legal, normal, cap, sh, up, dn, er, bz;
    int          last;
    legal  = (n >= 1) && (n <= 32);
    normal = legal && (abort_k == 0) && (rst_k == 0);
    snap   = chain;
    exp_rd = '0;
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        if (i < ch_len) exp_rd[i] = snap[i];
        else            exp_rd[i] = w[i - ch_len];
      end
    end
    m = (64'd1 << n) - 64'd1;
    exp_chain = ((snap >> n) | ((64'(w) & m) << (ch_len - n))) & ((64'd1 << ch_len) - 64'd1);

    start = 1'b1;
    len   = 6'(n);
    wdata = w;
    @(negedge clk);
    start = 1'b0;
    last = legal ? n + 6 : 4;
    for (int c = 1; c <= last; c++) begin
      cap = (c == 1);
      sh  = (c >= 2) && (c <= n + 1);
      up  = (c == n + 2);
      dn  = (c == n + 3);
      bz  = (c <= n + 3);
      er  = 1'b0;
      if (!legal) begin
        cap = 0; sh = 0; up = 0; dn = 0;
        er = (c == 1); bz = (c == 1);
      end
      if (abort_k > 0 && c > abort_k) begin
        cap = 0; sh = 0; up = 0; dn = 0;
        er = (c == abort_k + 1); bz = er;
      end
      if (rst_k > 0 && c > rst_k) begin
        cap = 0; sh = 0; up = 0; dn = 0; er = 0; bz = 0;
      end
      exp_v = {cap | sh | up, cap, sh, up, dn, er, bz};
      obs_v = {Select, CaptureEN, ShiftEN, UpdateEn, done, err, busy};
      check($sformatf("ctl n=%0d c=%0d", n, c), 64'(obs_v), 64'(exp_v));
      if (normal && c == n + 3) check($sformatf("rdata_at_done n=%0d", n), 64'(rdata), 64'(exp_rd));
      abort = (abort_k > 0) && (c == abort_k);
      start = (restart_k > 0) && (c == restart_k);
      rst   = (rst_k > 0) && (c >= rst_k) && (c <= rst_k + 1);
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    rst   = 1'b0;
    if (normal) begin
      rd_model = exp_rd;
      check($sformatf("chain n=%0d", n), chain, exp_chain);
    end else if (rst_k > 0) begin
      rd_model = '0;
    end
    check($sformatf("rdata_hold n=%0d", n), 64'(rdata), 64'(rd_model));
  endtask

  initial begin
    // Reset held for two cycles.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({Select, CaptureEN, ShiftEN, UpdateEn, done, err, busy, ScanSI}), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", 64'({Select, CaptureEN, ShiftEN, UpdateEn, done, err, busy}), 64'd0);

    // Loopback through an 8-bit chain preloaded with 0x3C.
    set_chain(8, 64'h3C);
    do_access(8, 32'hA5, 0, 0, 0);
    check("loop_rdata", 64'(rdata), 64'h3C);
    check("loop_chain", chain, 64'hA5);

    // Illegal lengths.
    do_access(0, 32'hDEAD_BEEF, 0, 0, 0);
    do_access(33, 32'h1234_5678, 0, 0, 0);
    check("illegal_rdata", 64'(rdata), 64'h3C);

    // Abort in the 5th SHIFT cycle of a 16-bit access.
    set_chain(40, {$urandom, $urandom});
    do_access(16, $urandom, 6, 0, 0);

    // start pulsed again during SHIFT of a 4-bit access.
    do_access(4, $urandom, 0, 3, 0);

    // Reset in the 3rd SHIFT cycle of an 8-bit access, then a 1-bit access.
    do_access(8, $urandom, 0, 0, 4);
    do_access(1, $urandom, 0, 0, 0);

    // Full-length access.
    do_access(32, $urandom, 0, 0, 0);

    // Random requests, some illegal, some aborted.
    for (int t = 0; t < 24; t++) begin
      int n, k;
      n = int'($urandom_range(0, 36));
      k = 0;
      if (n >= 1 && n <= 32 && $urandom_range(0, 3) == 0) k = int'($urandom_range(1, n + 1));
      do_access(n, $urandom, k, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
